// File: rtl/rv_pkg.sv
// Shared decode-interface types: hazard codes, fetch FSM states and the canonical NOP.
package rv_pkg;

  typedef enum logic [1:0] {
    HZ_NORMAL = 2'b00,
    HZ_FLUSH  = 2'b01,
    HZ_HOLD   = 2'b10
  } hazard_e;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DROP
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch stage and the memory.
interface fetch_unit_if #(
  parameter int unsigned XLEN = 32
) ();

  logic            im_req;
  logic [XLEN-1:0] im_addr;
  logic [XLEN-1:0] im_rdata;
  logic            im_rvalid;

  modport master (
    output im_req,
    output im_addr,
    input  im_rdata,
    input  im_rvalid
  );

  modport slave (
    input  im_req,
    input  im_addr,
    output im_rdata,
    output im_rvalid
  );

endinterface

// File: rtl/fetch_skid_buf.sv
// One-entry instruction+pc holding register used to park a response that lands during a stall.
module fetch_skid_buf
  import rv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            clear,
  input  logic [XLEN-1:0] instr_in,
  input  logic [XLEN-1:0] pc_in,
  output logic            valid,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] pc
);

  logic            valid_q;
  logic [XLEN-1:0] instr_q;
  logic [XLEN-1:0] pc_q;

  // Clear wins so a redirect can never leave a stale entry behind.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      instr_q <= XLEN'(NOP_INSTR);
      pc_q    <= '0;
    end else if (clear) begin
      valid_q <= 1'b0;
    end else if (load) begin
      valid_q <= 1'b1;
      instr_q <= instr_in;
      pc_q    <= pc_in;
    end
  end

  assign valid = valid_q;
  assign instr = instr_q;
  assign pc    = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, keeps one memory request outstanding, feeds decode.
// Define FETCH_PERF_CNT_EN to add saturating perf_fetched / perf_bubbles counters.
module fetch_unit
  import rv_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  fetch_unit_if.master    im,
  output logic [XLEN-1:0] instr_o,
  output logic [XLEN-1:0] instr_buf_o,
  output logic [XLEN-1:0] pc_o,
  output hazard_e         hazard_reg_o
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]     perf_fetched,
  output logic [31:0]     perf_bubbles
`endif
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;
  logic            im_req_q, im_req_d;
  logic [XLEN-1:0] im_addr_q, im_addr_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] buf_q, buf_d;
  logic [XLEN-1:0] pc_out_q, pc_out_d;
  hazard_e         hazard_q, hazard_d;

  logic            skid_valid, skid_load, skid_clear;
  logic [XLEN-1:0] skid_instr, skid_pc;
  logic            cand, issue;
  logic [XLEN-1:0] redirect_tgt;
  logic            unused_redirect_lsb;

  assign redirect_tgt        = {redirect_pc[XLEN-1:2], 2'b00};
  assign unused_redirect_lsb = ^redirect_pc[1:0];

  assign cand  = (state_q == WAIT) && im.im_rvalid;
  assign issue = (state_q == IDLE) && !skid_valid && !redirect_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (issue) state_d = WAIT;
      WAIT: begin
        if (im.im_rvalid)        state_d = IDLE;
        else if (redirect_valid) state_d = DROP;
      end
      DROP: if (im.im_rvalid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pc_d       = pc_q;
    req_pc_d   = req_pc_q;
    im_req_d   = issue;
    im_addr_d  = im_addr_q;
    instr_d    = instr_q;
    buf_d      = buf_q;
    pc_out_d   = pc_out_q;
    hazard_d   = hazard_q;
    skid_load  = 1'b0;
    skid_clear = 1'b0;

    if (issue) begin
      im_addr_d = pc_q;
      req_pc_d  = pc_q;
      pc_d      = pc_q + XLEN'(4);
    end

    if (redirect_valid) begin
      pc_d       = redirect_tgt;
      hazard_d   = HZ_FLUSH;
      instr_d    = XLEN'(NOP_INSTR);
      skid_clear = 1'b1;
    end else if (stall) begin
      hazard_d  = HZ_HOLD;
      skid_load = cand;
    end else if (skid_valid) begin
      hazard_d   = HZ_NORMAL;
      instr_d    = skid_instr;
      buf_d      = skid_instr;
      pc_out_d   = skid_pc;
      skid_clear = 1'b1;
    end else if (cand) begin
      hazard_d = HZ_NORMAL;
      instr_d  = im.im_rdata;
      buf_d    = im.im_rdata;
      pc_out_d = req_pc_q;
    end else begin
      hazard_d = HZ_FLUSH;
      instr_d  = XLEN'(NOP_INSTR);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q      <= RESET_PC;
      req_pc_q  <= RESET_PC;
      im_req_q  <= 1'b0;
      im_addr_q <= RESET_PC;
      instr_q   <= XLEN'(NOP_INSTR);
      buf_q     <= XLEN'(NOP_INSTR);
      pc_out_q  <= RESET_PC;
      hazard_q  <= HZ_FLUSH;
    end else begin
      pc_q      <= pc_d;
      req_pc_q  <= req_pc_d;
      im_req_q  <= im_req_d;
      im_addr_q <= im_addr_d;
      instr_q   <= instr_d;
      buf_q     <= buf_d;
      pc_out_q  <= pc_out_d;
      hazard_q  <= hazard_d;
    end
  end

  fetch_skid_buf #(
    .XLEN(XLEN)
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .load     (skid_load),
    .clear    (skid_clear),
    .instr_in (im.im_rdata),
    .pc_in    (req_pc_q),
    .valid    (skid_valid),
    .instr    (skid_instr),
    .pc       (skid_pc)
  );

  assign im.im_req    = im_req_q;
  assign im.im_addr   = im_addr_q;
  assign instr_o      = instr_q;
  assign instr_buf_o  = buf_q;
  assign pc_o         = pc_out_q;
  assign hazard_reg_o = hazard_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetched_q, bubbles_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetched_q <= '0;
      bubbles_q <= '0;
    end else begin
      if (hazard_d == HZ_NORMAL && fetched_q != 32'hFFFF_FFFF) fetched_q <= fetched_q + 32'd1;
      if (hazard_d == HZ_FLUSH && bubbles_q != 32'hFFFF_FFFF) bubbles_q <= bubbles_q + 32'd1;
    end
  end

  assign perf_fetched = fetched_q;
  assign perf_bubbles = bubbles_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: memory model + scoreboard of program-order presentations,
// a redirect/latency vector table and hand-written stall, redirect and reset sequences.
module tb_fetch_unit;
  import rv_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] instr_o, instr_buf_o, pc_o;
  hazard_e     hazard_reg_o;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched, perf_bubbles;
`endif

  fetch_unit_if #(.XLEN(32)) im ();

  fetch_unit #(
    .XLEN     (32),
    .RESET_PC (RST_PC)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .im             (im),
    .instr_o        (instr_o),
    .instr_buf_o    (instr_buf_o),
    .pc_o           (pc_o),
    .hazard_reg_o   (hazard_reg_o)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_bubbles   (perf_bubbles)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } sb_t;

  typedef struct {
    int unsigned lat;
    logic [31:0] target;
    int unsigned n;
    logic [31:0] exp_last_pc;
    logic [31:0] exp_last_instr;
  } row_t;

  int          n_checks = 0;
  int          n_pass   = 0;
  sb_t         sb_q[$];
  int          sb_epoch = 0, sb_seen = 0, sb_count = 0;
  logic [31:0] sb_base = 32'h0;
  int          pres_cnt = 0, hold_cnt = 0;
  logic [31:0] dut_last_pc = 32'h0, dut_last_instr = 32'h0;
  logic [31:0] last_pc = RST_PC, last_instr = NOP_INSTR;
  int unsigned lat = 1;
  logic [31:0] next_fetch = RST_PC, req_a = 32'h0;
  bit          busy = 1'b0;
  int          cnt = 0, stray = 0;
  row_t        rows[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  task automatic set_sb(input logic [31:0] base, input int n);
    sb_base  = base;
    sb_count = n;
    sb_epoch++;
  endtask

  // Memory model (mem[a] = a + 0x100) and output monitor, both sampled on the falling edge.
  task automatic bg_loop();
    sb_t e;
    forever begin
      @(negedge clk);
      if (sb_epoch != sb_seen) begin
        sb_seen = sb_epoch;
        sb_q.delete();
        for (int k = 0; k < sb_count; k++) begin
          e.pc    = sb_base + 32'(4 * k);
          e.instr = e.pc + 32'h100;
          sb_q.push_back(e);
        end
        next_fetch = sb_base;
      end

      im.im_rvalid = 1'b0;
      if (stray > 0) begin
        stray--;
        if (stray == 0) begin
          im.im_rvalid = 1'b1;
          im.im_rdata  = 32'hDEAD_BEEF;
        end
      end
      if (busy) begin
        cnt--;
        if (cnt == 0) begin
          im.im_rvalid = 1'b1;
          im.im_rdata  = req_a + 32'h100;
          busy         = 1'b0;
        end
      end
      // A request abandoned by reset still answers later, as a stray strobe.
      if (!rst && busy) begin
        stray = cnt;
        busy  = 1'b0;
      end
      if (rst && im.im_req) begin
        check("one_outstanding", 32'(busy), 32'd0);
        check("im_addr", im.im_addr, next_fetch);
        next_fetch = next_fetch + 32'd4;
        busy       = 1'b1;
        cnt        = int'(lat);
        req_a      = im.im_addr;
      end

      if (!rst) begin
        last_pc    = RST_PC;
        last_instr = NOP_INSTR;
      end else if (hazard_reg_o == HZ_NORMAL) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          $display("FAIL present_unexpected: got pc 0x%08h with empty scoreboard at %0t",
                   pc_o, $time);
        end else begin
          e = sb_q.pop_front();
          check("pres_pc", pc_o, e.pc);
          check("pres_instr", instr_o, e.instr);
          check("pres_buf", instr_buf_o, e.instr);
          last_pc        = e.pc;
          last_instr     = e.instr;
          dut_last_pc    = pc_o;
          dut_last_instr = instr_o;
          pres_cnt++;
        end
      end else if (hazard_reg_o == HZ_HOLD) begin
        check("hold_buf", instr_buf_o, last_instr);
        check("hold_pc", pc_o, last_pc);
        hold_cnt++;
      end else if (hazard_reg_o == HZ_FLUSH) begin
        check("bubble_nop", instr_o, NOP_INSTR);
      end else begin
        check("hazard_code", 32'(hazard_reg_o), 32'(HZ_FLUSH));
      end
    end
  endtask

  task automatic wait_pres(input int target, input int budget, output int cycles);
    cycles = 0;
    while (pres_cnt < target && cycles < budget) begin
      @(negedge clk);
      #1;
      cycles++;
    end
    check("wait_pres", 32'(pres_cnt >= target), 32'd1);
  endtask

  task automatic wait_req(input logic [31:0] addr, input bit any, input int budget);
    int  c = 0;
    bit  hit = 1'b0;
    while (!hit && c < budget) begin
      @(negedge clk);
      #1;
      c++;
      hit = im.im_req && (any || im.im_addr == addr);
    end
    check("wait_req", 32'(hit), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_hazard"}, 32'(hazard_reg_o), 32'(HZ_FLUSH));
    check({tag, "_instr"}, instr_o, NOP_INSTR);
    check({tag, "_buf"}, instr_buf_o, NOP_INSTR);
    check({tag, "_pc"}, pc_o, RST_PC);
    check({tag, "_im_req"}, 32'(im.im_req), 32'd0);
    check({tag, "_im_addr"}, im.im_addr, RST_PC);
`ifdef FETCH_PERF_CNT_EN
    check({tag, "_perf_fetched"}, perf_fetched, 32'd0);
    check({tag, "_perf_bubbles"}, perf_bubbles, 32'd0);
`endif
  endtask

  initial begin
    int cyc;
    int base;
    int h0;
    rst            = 1'b0;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    im.im_rvalid   = 1'b0;
    im.im_rdata    = 32'h0;
    rows[0] = '{1, 32'h0000_0200, 3, 32'h0000_0208, 32'h0000_0308};
    rows[1] = '{3, 32'h0000_1000, 3, 32'h0000_1008, 32'h0000_1108};
    rows[2] = '{2, 32'hFFFF_FFF8, 3, 32'h0000_0000, 32'h0000_0100};
    rows[3] = '{1, 32'h0000_0041, 2, 32'h0000_0044, 32'h0000_0144};
    fork
      bg_loop();
    join_none

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst");

    // Release: first request one cycle later, first 00 two cycles after that.
    set_sb(RST_PC, 12);
    lat = 1;
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    #1;
    check("first_idle_hazard", 32'(hazard_reg_o), 32'(HZ_FLUSH));
    check("first_idle_req", 32'(im.im_req), 32'd0);
    @(negedge clk);
    #1;
    check("first_req", 32'(im.im_req), 32'd1);
    check("first_addr", im.im_addr, RST_PC);
    wait_pres(1, 10, cyc);
    check("first_present_latency", cyc, 32'd2);

    // Stall for 3 cycles while pc 8 is returning.
    wait_req(32'h8, 1'b0, 40);
    @(posedge clk);
    #1 stall = 1'b1;
    h0 = hold_cnt;
    repeat (3) @(posedge clk);
    #1 stall = 1'b0;
    wait_pres(3, 20, cyc);
    check("stall_hold_cycles", hold_cnt - h0, 32'd3);
    check("stall_skid_pc", dut_last_pc, 32'h8);

    // Redirect while the request to pc 12 is outstanding.
    wait_req(32'hC, 1'b0, 40);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    @(posedge clk);
    #1 redirect_valid = 1'b0;
    set_sb(32'h40, 6);
    base = pres_cnt;
    @(negedge clk);
    #1;
    check("redir_hazard", 32'(hazard_reg_o), 32'(HZ_FLUSH));
    wait_pres(base + 1, 30, cyc);
    check("redir_first_pc", dut_last_pc, 32'h40);

    // Redirect and stall together: redirect wins, low target bits dropped.
    @(posedge clk);
    #1;
    stall          = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h83;
    @(posedge clk);
    #1;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    set_sb(32'h80, 6);
    base = pres_cnt;
    @(negedge clk);
    #1;
    check("redir_stall_hazard", 32'(hazard_reg_o), 32'(HZ_FLUSH));
    wait_pres(base + 1, 30, cyc);
    check("redir_stall_pc", dut_last_pc, 32'h80);

    // Table: redirect target and memory latency per row.
    for (int i = 0; i < 4; i++) begin
      lat = rows[i].lat;
      @(posedge clk);
      #1;
      redirect_valid = 1'b1;
      redirect_pc    = rows[i].target;
      @(posedge clk);
      #1 redirect_valid = 1'b0;
      set_sb(rows[i].target & 32'hFFFF_FFFC, int'(rows[i].n) + 4);
      base = pres_cnt;
      wait_pres(base + int'(rows[i].n), 80, cyc);
      check($sformatf("row%0d_last_pc", i), dut_last_pc, rows[i].exp_last_pc);
      check($sformatf("row%0d_last_instr", i), dut_last_instr, rows[i].exp_last_instr);
    end

    // Reset mid-WAIT; the stale strobe lands on the first cycle after release.
    lat = 3;
    wait_req(32'h0, 1'b1, 40);
    @(posedge clk);
    #1 rst = 1'b0;
    set_sb(RST_PC, 6);
    @(negedge clk);
    #1;
    check_reset_outputs("midreset");
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    base = pres_cnt;
    wait_pres(base + 1, 40, cyc);
    check("post_reset_pc", dut_last_pc, RST_PC);
    check("post_reset_instr", dut_last_instr, 32'h100);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage and producer side of the decode-stage instruction interface.
- Owns the PC and issues requests to the synchronous instruction memory, one outstanding request at a time.
- Presents instruction, PC and the 2-bit hazard_reg code that decode consumes: 00 normal, 01 flush/bubble (decode injects 32'h13), 10 hold (decode re-uses the buffered instruction).
- Sits between instruction memory and decode; takes stall from hazard detection and redirects from EX.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- XLEN, 32, address and instruction width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- stall  in  1  load-use hold from hazard detection.
- redirect_valid  in  1  branch taken or jump resolved in EX.
- redirect_pc  in  XLEN  redirect target; bits [1:0] ignored and forced to 0.
- im_req  out  1  single-cycle fetch request pulse.
- im_addr  out  XLEN  fetch address, valid while im_req=1.
- im_rdata  in  XLEN  instruction memory read data.
- im_rvalid  in  1  response strobe, at least 1 cycle after im_req.
- instr_o  out  XLEN  instruction to decode (IM_data_in side).
- instr_buf_o  out  XLEN  last instruction accepted by decode (IM_data_buf side).
- pc_o  out  XLEN  PC of instr_o (pc_from_IF side).
- hazard_reg_o  out  2  00 normal, 01 bubble, 10 hold.

Behaviour:
- All outputs registered.
- Reset values:
  - pc_q = RESET_PC.
  - instr_o and instr_buf_o = 32'h13.
  - pc_o = RESET_PC.
  - hazard_reg_o = 01.
  - im_req = 0, im_addr = RESET_PC.
  - state = IDLE, skid empty.
- States:
  - IDLE: nothing outstanding.
  - WAIT: one request outstanding; req_pc holds its address.
  - DROP: one request outstanding whose response must be discarded.
- Request issue happens in IDLE when skid is empty and redirect_valid=0:
  - im_req=1, im_addr=pc_q.
  - req_pc<=pc_q, pc_q<=pc_q+4 (wraps modulo 2^32).
  - Go to WAIT.
- im_rvalid handling:
  - In WAIT: go to IDLE; the response is the candidate this cycle.
  - In DROP: discard it and go to IDLE.
  - In IDLE: ignore it; no state change.
- Per-cycle output priority, highest first:
  1. redirect_valid: hazard_reg_o<=01, pc_q<=redirect_pc, skid cleared, any candidate discarded. WAIT goes to DROP. The first new request issues on the first IDLE cycle after the redirect cycle. Redirect beats stall.
  2. stall: hazard_reg_o<=10; instr_o, pc_o and instr_buf_o unchanged. A candidate arriving this cycle is captured in the 1-entry skid with its pc; no new request issues while skid is full.
  3. skid full: present skid contents (instr_o, pc_o, instr_buf_o<=skid instr), hazard_reg_o<=00, clear skid.
  4. Candidate present: same as 3, using im_rdata and req_pc.
  5. Otherwise: hazard_reg_o<=01, instr_o<=32'h13.
- Ordering:
  - Each instruction is presented with 00 exactly once.
  - No instruction is lost or duplicated across stall.
  - Presentation order equals program order.
- Fetch-to-decode latency is 2 cycles with 1-cycle memory: request cycle, then response cycle with a registered present.
- Stall held indefinitely: outputs frozen at hold (10), at most 1 request outstanding, skid holds at most 1 entry.
- Asynchronous reset assertion mid-request abandons the request. A stray im_rvalid after release is ignored because the state is IDLE.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- Defined:
  - Adds 32-bit outputs perf_fetched (increments on each hazard_reg_o<=00) and perf_bubbles (increments on each hazard_reg_o<=01).
  - Both saturate at 32'hFFFF_FFFF and reset to 0.
- Undefined: the ports and counters are absent. All other behaviour is identical.

Decomposition:
- Shared package rv_pkg:
  - Enum hazard_e {HZ_NORMAL=2'b00, HZ_FLUSH=2'b01, HZ_HOLD=2'b10}.
  - Constant NOP_INSTR=32'h13.
  - State enum fetch_state_e {IDLE, WAIT, DROP}.
- Sub-module fetch_skid_buf: 1-entry instruction+pc holding register with valid flag, load and clear.
- The FSM and PC stay in fetch_unit.

Test Plan:
- Reset release, 1-cycle memory returning mem[a]=a+32'h100, no stall → im_addr 0,4,8,… on successive requests; instr_o 32'h100 with pc_o 0 and hazard 00, then 32'h104 with pc_o 4 and hazard 00, … with a bubble (01) between each.
- Stall asserted 3 cycles while instruction at pc 8 is returning → hazard 10 for 3 cycles with instr_buf_o unchanged; then pc 8 is presented with 00 from the skid; no duplicate, no skip.
- Redirect to 32'h40 while request to pc 12 is outstanding → hazard 01; pc 12 data is dropped; next im_addr is 32'h40; next 00 output has pc_o=32'h40.
- Redirect and stall in the same cycle → redirect wins: hazard 01, pc_q=redirect_pc.
- Memory latency 3 cycles → exactly one outstanding request; hazard 01 while waiting; correct ordering.
- Reset asserted mid-WAIT, then released while the stale im_rvalid arrives → rvalid is ignored; fetch restarts at RESET_PC. With FETCH_PERF_CNT_EN, counters read 0 after reset.
